// File: rtl/mem_stage_memwb_pkg.sv
// Shared widths and access-size encodings for the MIPS memory stage.
package mem_stage_memwb_pkg;

    localparam int unsigned BITS_SIZE     = 32;
    localparam int unsigned BITS_REGS     = 5;
    localparam int unsigned MEM_ADDR_BITS = 5;
    localparam int unsigned MEM_DEPTH     = 1 << MEM_ADDR_BITS;
    localparam int unsigned LANES         = BITS_SIZE / 8;

    localparam logic [1:0] SIZE_WORD    = 2'b00;
    localparam logic [1:0] SIZE_BYTE    = 2'b01;
    localparam logic [1:0] SIZE_HALF    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    // Byte-lane write enables for an aligned access of the given size at byte offset.
    function automatic logic [LANES-1:0] lane_enables(input logic [1:0] size, input logic [1:0] offset);
        logic [LANES-1:0] en;
        en = '0;
        case (size)
            SIZE_WORD: en = 4'b1111;
            SIZE_BYTE: en = 4'b0001 << offset;
            SIZE_HALF: en = offset[1] ? 4'b1100 : 4'b0011;
            default:   en = '0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/mem_stage_memwb_data_memory_lanes.sv
// Word-organised data memory with per-byte-lane writes, combinational read and debug read port.
module data_memory_lanes
    import mem_stage_memwb_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_we,
    input  logic [LANES-1:0]         i_byte_en,
    input  logic [MEM_ADDR_BITS-1:0] i_addr,
    input  logic [BITS_SIZE-1:0]     i_wdata,
    output logic [BITS_SIZE-1:0]     o_rdata,
    input  logic [MEM_ADDR_BITS-1:0] i_debug_addr,
    output logic [BITS_SIZE-1:0]     o_debug_data
);

    logic [BITS_SIZE-1:0] r_mem [MEM_DEPTH];

    // Clear on reset; otherwise write only the enabled byte lanes of the addressed word.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int b = 0; b < int'(LANES); b++) begin
                if (i_byte_en[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata      = r_mem[i_addr];
    assign o_debug_data = r_mem[i_debug_addr];

endmodule

// File: rtl/mem_stage_memwb.sv
// MIPS MEM stage: data memory access, load alignment, misalignment fault and MEM/WB latch.
module mem_stage_memwb
    import mem_stage_memwb_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic                     i_flush,
    input  logic [BITS_SIZE-1:0]     i_exmem_alu,
    input  logic [BITS_SIZE-1:0]     i_exmem_store_data,
    input  logic [BITS_SIZE-1:0]     i_exmem_extension,
    input  logic [BITS_REGS-1:0]     i_exmem_rd,
    input  logic                     i_exmem_mem_read,
    input  logic                     i_exmem_mem_write,
    input  logic [1:0]               i_exmem_size,
    input  logic                     i_exmem_zero_extend,
    input  logic                     i_exmem_lui,
    input  logic                     i_exmem_mem_to_reg,
    input  logic                     i_exmem_reg_write,
    input  logic                     i_exmem_halt,
    input  logic [MEM_ADDR_BITS-1:0] i_debug_addr,
    output logic [BITS_SIZE-1:0]     o_debug_data,
    output logic [BITS_SIZE-1:0]     o_memwb_alu,
    output logic [BITS_SIZE-1:0]     o_memwb_dato_mem,
    output logic [BITS_SIZE-1:0]     o_memwb_extension,
    output logic [BITS_REGS-1:0]     o_memwb_rd,
    output logic [1:0]               o_memwb_size,
    output logic                     o_memwb_zero_extend,
    output logic                     o_memwb_lui,
    output logic                     o_memwb_mem_to_reg,
    output logic                     o_memwb_reg_write,
    output logic                     o_memwb_halt,
    output logic                     o_misaligned
);

    logic [MEM_ADDR_BITS-1:0] w_word_idx;
    logic [1:0]               w_offset;
    logic                     w_access;
    logic                     w_misaligned;
    logic                     w_store_en;
    logic [LANES-1:0]         w_byte_en;
    logic [BITS_SIZE-1:0]     w_wdata;
    logic [BITS_SIZE-1:0]     w_rdata;
    logic [BITS_SIZE-1:0]     w_load_data;
    logic                     w_unused_alu_hi;

    // Address split; upper address bits wrap around the memory.
    assign w_word_idx      = i_exmem_alu[MEM_ADDR_BITS+1:2];
    assign w_offset        = i_exmem_alu[1:0];
    assign w_unused_alu_hi = ^i_exmem_alu[BITS_SIZE-1:MEM_ADDR_BITS+2];

    // Alignment check, only meaningful when the instruction touches memory.
    assign w_access     = i_exmem_mem_read | i_exmem_mem_write;
    assign w_misaligned = w_access &
                          (((i_exmem_size == SIZE_HALF) & w_offset[0]) |
                           ((i_exmem_size == SIZE_WORD) & (w_offset != 2'b00)) |
                           (i_exmem_size == SIZE_ILLEGAL));

    // Replicate store data across lanes so each enabled lane picks its own copy.
    always_comb begin
        w_wdata = i_exmem_store_data;
        case (i_exmem_size)
            SIZE_BYTE: w_wdata = {4{i_exmem_store_data[7:0]}};
            SIZE_HALF: w_wdata = {2{i_exmem_store_data[15:0]}};
            default:   w_wdata = i_exmem_store_data;
        endcase
    end

    assign w_byte_en  = lane_enables(i_exmem_size, w_offset);
    assign w_store_en = i_reset & i_enable & i_exmem_mem_write & ~w_misaligned;

    data_memory_lanes u_data_memory_lanes (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_we         (w_store_en),
        .i_byte_en    (w_byte_en),
        .i_addr       (w_word_idx),
        .i_wdata      (w_wdata),
        .o_rdata      (w_rdata),
        .i_debug_addr (i_debug_addr),
        .o_debug_data (o_debug_data)
    );

    // Right-justify load data; sign/zero extension happens in the writeback mux.
    assign w_load_data = w_rdata >> {w_offset, 3'b000};

    // MEM/WB latch with bubble insertion and sticky misalignment fault.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_memwb_alu         <= '0;
            o_memwb_dato_mem    <= '0;
            o_memwb_extension   <= '0;
            o_memwb_rd          <= '0;
            o_memwb_size        <= '0;
            o_memwb_zero_extend <= 1'b0;
            o_memwb_lui         <= 1'b0;
            o_memwb_mem_to_reg  <= 1'b0;
            o_memwb_reg_write   <= 1'b0;
            o_memwb_halt        <= 1'b0;
            o_misaligned        <= 1'b0;
        end else if (i_enable) begin
            o_memwb_alu         <= i_exmem_alu;
            o_memwb_dato_mem    <= w_load_data;
            o_memwb_extension   <= i_exmem_extension;
            o_memwb_rd          <= i_exmem_rd;
            o_memwb_size        <= i_exmem_size;
            o_memwb_zero_extend <= i_exmem_zero_extend;
            o_memwb_lui         <= i_exmem_lui & ~i_flush;
            o_memwb_halt        <= i_exmem_halt & ~i_flush;
            o_memwb_mem_to_reg  <= i_exmem_mem_to_reg & ~i_flush & ~w_misaligned;
            o_memwb_reg_write   <= i_exmem_reg_write & ~i_flush & ~w_misaligned;
            o_misaligned        <= o_misaligned | w_misaligned;
        end
    end

endmodule

// File: tb/tb_mem_stage_memwb.sv
// Self-checking bench for mem_stage_memwb: directed scenarios plus randomized traffic vs a behavioural model.
module tb_mem_stage_memwb;

    logic        clk = 1'b0;
    logic        reset, enable, flush;
    logic [31:0] alu, sd, ext;
    logic [4:0]  rd;
    logic        mrd, mwr, ze, lui, m2r, rw, halt;
    logic [1:0]  size;
    logic [4:0]  dbg;

    logic [31:0] o_debug_data, o_alu, o_dato, o_ext;
    logic [4:0]  o_rd;
    logic [1:0]  o_size;
    logic        o_ze, o_lui, o_m2r, o_rw, o_halt, o_mis;

    // Reference model state
    logic [31:0] m_mem [32];
    logic [31:0] m_alu, m_dato, m_ext;
    logic [4:0]  m_rd;
    logic [1:0]  m_size;
    logic        m_ze, m_lui, m_m2r, m_rw, m_halt, m_mis;

    int n_cmp = 0;
    int n_err = 0;
    bit skip_data_chk = 0;

    always #5 clk = ~clk;

    mem_stage_memwb dut (
        .i_clk               (clk),
        .i_reset             (reset),
        .i_enable            (enable),
        .i_flush             (flush),
        .i_exmem_alu         (alu),
        .i_exmem_store_data  (sd),
        .i_exmem_extension   (ext),
        .i_exmem_rd          (rd),
        .i_exmem_mem_read    (mrd),
        .i_exmem_mem_write   (mwr),
        .i_exmem_size        (size),
        .i_exmem_zero_extend (ze),
        .i_exmem_lui         (lui),
        .i_exmem_mem_to_reg  (m2r),
        .i_exmem_reg_write   (rw),
        .i_exmem_halt        (halt),
        .i_debug_addr        (dbg),
        .o_debug_data        (o_debug_data),
        .o_memwb_alu         (o_alu),
        .o_memwb_dato_mem    (o_dato),
        .o_memwb_extension   (o_ext),
        .o_memwb_rd          (o_rd),
        .o_memwb_size        (o_size),
        .o_memwb_zero_extend (o_ze),
        .o_memwb_lui         (o_lui),
        .o_memwb_mem_to_reg  (o_m2r),
        .o_memwb_reg_write   (o_rw),
        .o_memwb_halt        (o_halt),
        .o_misaligned        (o_mis)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        reset = 1'b1; enable = 1'b1; flush = 1'b0;
        alu = '0; sd = '0; ext = '0; rd = '0;
        mrd = 0; mwr = 0; size = 2'b00; ze = 0; lui = 0; m2r = 0; rw = 0; halt = 0;
        dbg = '0;
    endtask

    // Next model state from the current inputs (evaluated just before the edge).
    task automatic model_step();
        int unsigned off, idx, sh;
        logic [31:0] mask, word;
        logic acc, mis;
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_mem[i] = '0;
            m_alu = 0; m_dato = 0; m_ext = 0; m_rd = 0; m_size = 0;
            m_ze = 0; m_lui = 0; m_m2r = 0; m_rw = 0; m_halt = 0; m_mis = 0;
        end else if (enable) begin
            off  = alu % 4;
            idx  = (alu / 4) % 32;
            acc  = mrd | mwr;
            mis  = acc && ((size == 2 && (off % 2) == 1) || (size == 0 && off != 0) || size == 3);
            word = m_mem[idx];
            m_dato = word >> (8 * off);
            if (mwr && !mis) begin
                if (size == 0) begin
                    m_mem[idx] = sd;
                end else if (size == 1) begin
                    mask = 32'hFF << (8 * off);
                    m_mem[idx] = (word & ~mask) | ((sd & 32'hFF) << (8 * off));
                end else begin
                    sh   = (off / 2) * 16;
                    mask = 32'hFFFF << sh;
                    m_mem[idx] = (word & ~mask) | ((sd & 32'hFFFF) << sh);
                end
            end
            m_alu = alu; m_ext = ext; m_rd = rd; m_size = size; m_ze = ze;
            m_lui  = lui  && !flush;
            m_halt = halt && !flush;
            m_m2r  = m2r && !flush && !mis;
            m_rw   = rw  && !flush && !mis;
            m_mis  = m_mis | mis;
        end
    endtask

    task automatic chk_outputs();
        if (!skip_data_chk) begin
            chk("alu",  o_alu,  m_alu);
            chk("dato", o_dato, m_dato);
            chk("ext",  o_ext,  m_ext);
        end
        chk("rd",   32'(o_rd),   32'(m_rd));
        chk("size", 32'(o_size), 32'(m_size));
        chk("ze",   32'(o_ze),   32'(m_ze));
        chk("lui",  32'(o_lui),  32'(m_lui));
        chk("m2r",  32'(o_m2r),  32'(m_m2r));
        chk("rw",   32'(o_rw),   32'(m_rw));
        chk("halt", 32'(o_halt), 32'(m_halt));
        chk("mis",  32'(o_mis),  32'(m_mis));
    endtask

    // One clock: check same-cycle debug read (old word), advance model, check latch.
    task automatic cycle();
        #1;
        chk("debug_pre", o_debug_data, m_mem[dbg]);
        model_step();
        @(posedge clk);
        #1;
        chk_outputs();
        chk("debug_post", o_debug_data, m_mem[dbg]);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_alu = 0; m_dato = 0; m_ext = 0; m_rd = 0; m_size = 0;
        m_ze = 0; m_lui = 0; m_m2r = 0; m_rw = 0; m_halt = 0; m_mis = 0;
        set_idle();
        @(negedge clk);

        // Reset
        reset = 1'b0;
        cycle();
        chk("reset_mis", 32'(o_mis), 32'h0);
        chk("reset_alu", o_alu, 32'h0);

        // Word store then word load
        set_idle(); alu = 32'h8; sd = 32'hDEADBEEF; mwr = 1; size = 2'b00; dbg = 5'd2;
        cycle();
        set_idle(); alu = 32'h8; mrd = 1; m2r = 1; rw = 1; rd = 5'd3; dbg = 5'd2;
        cycle();
        chk("word_load", o_dato, 32'hDEADBEEF);
        chk("word_dbg",  o_debug_data, 32'hDEADBEEF);

        // Byte store into lane 1, byte load from lane 3
        set_idle(); alu = 32'h9; sd = 32'h000000AA; mwr = 1; size = 2'b01; dbg = 5'd2;
        cycle();
        chk("byte_store", o_debug_data, 32'hDEADAAEF);
        set_idle(); alu = 32'hB; mrd = 1; m2r = 1; rw = 1; size = 2'b01; ze = 1; dbg = 5'd2;
        cycle();
        chk("byte_load", o_dato, 32'h000000DE);

        // Half store to upper half, then misaligned half load
        set_idle(); alu = 32'hA; sd = 32'h00001234; mwr = 1; size = 2'b10; dbg = 5'd2;
        cycle();
        chk("half_store", o_debug_data, 32'h1234AAEF);
        set_idle(); alu = 32'hB; mrd = 1; m2r = 1; rw = 1; size = 2'b10; dbg = 5'd2;
        cycle();
        chk("half_mis", 32'(o_mis), 32'h1);
        chk("half_mis_rw", 32'(o_rw), 32'h0);
        chk("half_mis_mem", o_debug_data, 32'h1234AAEF);

        // Freeze with a pending store for three cycles, then release
        set_idle(); enable = 0; alu = 32'h10; sd = 32'hCAFEF00D; mwr = 1; size = 2'b00;
        rd = 5'd7; rw = 1; halt = 1; dbg = 5'd4;
        for (int k = 0; k < 3; k++) cycle();
        chk("freeze_mem", o_debug_data, 32'h0);
        enable = 1;
        cycle();
        chk("release_mem",  o_debug_data, 32'hCAFEF00D);
        chk("release_halt", 32'(o_halt), 32'h1);

        // Flush during a load; data fields are don't-care under a bubble
        set_idle(); alu = 32'h10; mrd = 1; m2r = 1; rw = 1; flush = 1; rd = 5'd9;
        skip_data_chk = 1;
        cycle();
        skip_data_chk = 0;
        chk("flush_rw",  32'(o_rw),  32'h0);
        chk("flush_m2r", 32'(o_m2r), 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            set_idle();
            alu    = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 127));
            sd     = $urandom();
            ext    = $urandom();
            rd     = 5'($urandom());
            mrd    = 1'($urandom());
            mwr    = 1'($urandom());
            size   = 2'($urandom());
            ze     = 1'($urandom());
            lui    = 1'($urandom());
            m2r    = 1'($urandom());
            rw     = 1'($urandom());
            halt   = ($urandom_range(0, 15) == 0);
            enable = ($urandom_range(0, 7) != 0);
            flush  = ($urandom_range(0, 9) == 0);
            reset  = ($urandom_range(0, 99) != 0);
            dbg    = 5'($urandom());
            skip_data_chk = reset && enable && flush;
            cycle();
            skip_data_chk = 0;
        end

        // Reset after activity clears outputs and all memory
        set_idle(); alu = 32'h20; sd = 32'h55555555; mwr = 1; size = 2'b00;
        cycle();
        set_idle(); reset = 0; alu = 32'h24; sd = 32'h77777777; mwr = 1; rw = 1; halt = 1;
        cycle();
        set_idle();
        chk("post_reset_mis", 32'(o_mis), 32'h0);
        chk("post_reset_rw",  32'(o_rw),  32'h0);
        for (int a = 0; a < 32; a++) begin
            dbg = 5'(a);
            #1;
            chk("post_reset_dbg", o_debug_data, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
